// File: rtl/adc_spi_pkg.sv
// adc_spi_sequencer shared types
// FSM states, init-table entry layout, default table
package adc_spi_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ARB,
    WR,
    WR_WAIT,
    RD,
    RD_WAIT,
    CHK,
    USR,
    USR_WAIT
  } state_e;

  localparam int VERIFY_BIT = 32;
  localparam int READ_BIT   = 15;

  localparam logic [15:0] TMO_RD = 16'hDEAD;

  typedef logic [32:0] entry_t;
  typedef entry_t [31:0] table_t;

  function automatic table_t def_table();
    table_t t;
    t = '0;
    for (int i = 0; i < 32; i++) begin
      t[i] = {1'b1, 8'h00, 8'(16 + i),
              8'h00, 8'(160 + i)};
    end
    return t;
  endfunction

  localparam table_t DEF_TABLE = def_table();

endpackage

// File: rtl/adc_spi_sequencer_if.sv
// adc_spi_sequencer <-> spi_master bus
// master = sequencer side, slave = spi_master side
interface adc_spi_sequencer_if;

  logic        spi_start_o;
  logic [15:0] spi_wr_h_o;
  logic [15:0] spi_wr_l_o;
  logic [15:0] spi_rd_l_i;
  logic        spi_busy_i;

  modport master (
    output spi_start_o,
    output spi_wr_h_o,
    output spi_wr_l_o,
    input  spi_rd_l_i,
    input  spi_busy_i
  );

  modport slave (
    input  spi_start_o,
    input  spi_wr_h_o,
    input  spi_wr_l_o,
    output spi_rd_l_i,
    output spi_busy_i
  );

endinterface

// File: rtl/adc_cfg_rom.sv
// adc_cfg_rom: ADC init table
// combinational {verify, h, l} lookup
module adc_cfg_rom
  import adc_spi_pkg::*;
#(
  parameter int     N_CMD = 8,
  parameter table_t TABLE = DEF_TABLE
) (
  input  logic [4:0] idx_i,
  output entry_t     entry_o
);

  // indices past the populated range read as zero
  always_comb begin
    entry_o = '0;
    if ({1'b0, idx_i} < 6'(N_CMD)) begin
      entry_o = TABLE[idx_i];
    end
  end

endmodule

// File: rtl/adc_spi_sequencer.sv
// adc_spi_sequencer: shares one spi_master
// between the ADC init table and a user port
module adc_spi_sequencer
  import adc_spi_pkg::*;
#(
  parameter int          N_CMD = 8,
  parameter int          RETRY = 3,
  parameter logic [15:0] TMO   = 16'd16384,
  parameter table_t      TABLE = DEF_TABLE
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       init_start_i,
  output logic                       init_busy_o,
  output logic                       init_done_o,
  output logic                       init_err_o,
  output logic [4:0]                 err_idx_o,
  input  logic                       usr_req_i,
  input  logic [15:0]                usr_wr_h_i,
  input  logic [15:0]                usr_wr_l_i,
  output logic                       usr_ack_o,
  output logic [15:0]                usr_rd_o,
  adc_spi_sequencer_if.master        spi
);

  localparam logic [4:0]  LAST_IDX  = 5'(N_CMD - 1);
  localparam logic [7:0]  RETRY_MAX = 8'(RETRY);
  localparam logic [15:0] TMO_LAST  = TMO - 16'd1;

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [7:0]  retry_q, retry_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [4:0]  eidx_q, eidx_d;
  logic        rd_pend_q, rd_pend_d;
  logic        seen_q, seen_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] wr_h_q, wr_h_d;
  logic [15:0] wr_l_q, wr_l_d;
  logic        ack_q, ack_d;
  logic [15:0] rd_q, rd_d;

  entry_t entry;
  logic   xfer_done;
  logic   xfer_tmo;
  logic   adv;
  logic   fail;

  adc_cfg_rom #(
    .N_CMD (N_CMD),
    .TABLE (TABLE)
  ) u_rom (
    .idx_i   (idx_q),
    .entry_o (entry)
  );

  // completion: busy seen high, now low; else count toward abort
  assign xfer_done = seen_q & ~spi.spi_busy_i;
  assign xfer_tmo  = ~xfer_done & (cnt_q == TMO_LAST);

  // next state, entry bookkeeping and bus words
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    eidx_d    = eidx_q;
    rd_pend_d = rd_pend_q;
    seen_d    = seen_q;
    cnt_d     = cnt_q;
    wr_h_d    = wr_h_q;
    wr_l_d    = wr_l_q;
    ack_d     = 1'b0;
    rd_d      = rd_q;
    adv       = 1'b0;
    fail      = 1'b0;

    // a start while a user transfer runs waits in busy_q for ARB
    if (init_start_i && !busy_q) begin
      busy_d  = 1'b1;
      done_d  = 1'b0;
      err_d   = 1'b0;
      eidx_d  = '0;
      idx_d   = '0;
      retry_d = '0;
    end

    if (state_q inside {WR_WAIT, RD_WAIT, USR_WAIT}) begin
      seen_d = seen_q | spi.spi_busy_i;
      cnt_d  = cnt_q + 16'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (usr_req_i || init_start_i || busy_q) begin
          state_d = ARB;
        end
      end
      ARB: begin
        if (rd_pend_q) begin
          rd_pend_d        = 1'b0;
          wr_h_d           = entry[31:16];
          wr_h_d[READ_BIT] = 1'b1;
          wr_l_d           = '0;
          state_d          = RD;
        end else if (usr_req_i && !ack_q) begin
          wr_h_d  = usr_wr_h_i;
          wr_l_d  = usr_wr_l_i;
          state_d = USR;
        end else if (busy_q) begin
          wr_h_d           = entry[31:16];
          wr_h_d[READ_BIT] = 1'b0;
          wr_l_d           = entry[15:0];
          state_d          = WR;
        end else begin
          state_d = IDLE;
        end
      end
      WR, RD, USR: begin
        cnt_d  = 16'd1;
        seen_d = 1'b0;
        unique case (1'b1)
          state_q == WR: state_d = WR_WAIT;
          state_q == RD: state_d = RD_WAIT;
          default:       state_d = USR_WAIT;
        endcase
      end
      WR_WAIT: begin
        if (xfer_done) begin
          state_d = ARB;
          if (entry[VERIFY_BIT]) rd_pend_d = 1'b1;
          else                   adv       = 1'b1;
        end else if (xfer_tmo) begin
          fail    = 1'b1;
          state_d = ARB;
        end
      end
      RD_WAIT: begin
        if (xfer_done) begin
          state_d = CHK;
        end else if (xfer_tmo) begin
          fail    = 1'b1;
          state_d = ARB;
        end
      end
      CHK: begin
        if (spi.spi_rd_l_i[7:0] == entry[7:0]) begin
          adv     = 1'b1;
          state_d = ARB;
        end else if (retry_q < RETRY_MAX) begin
          retry_d          = retry_q + 8'd1;
          wr_h_d           = entry[31:16];
          wr_h_d[READ_BIT] = 1'b0;
          wr_l_d           = entry[15:0];
          state_d          = WR;
        end else begin
          fail    = 1'b1;
          state_d = ARB;
        end
      end
      USR_WAIT: begin
        if (xfer_done) begin
          ack_d   = 1'b1;
          rd_d    = spi.spi_rd_l_i;
          state_d = ARB;
        end else if (xfer_tmo) begin
          ack_d   = 1'b1;
          rd_d    = TMO_RD;
          state_d = ARB;
        end
      end
      default: state_d = IDLE;
    endcase

    if (adv) begin
      retry_d = '0;
      if (idx_q == LAST_IDX) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        idx_d = idx_q + 5'd1;
      end
    end

    if (fail) begin
      busy_d = 1'b0;
      err_d  = 1'b1;
      eidx_d = idx_q;
    end
  end

  // state and datapath registers, synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      retry_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      eidx_q    <= '0;
      rd_pend_q <= 1'b0;
      seen_q    <= 1'b0;
      cnt_q     <= '0;
      wr_h_q    <= '0;
      wr_l_q    <= '0;
      ack_q     <= 1'b0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      retry_q   <= retry_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      eidx_q    <= eidx_d;
      rd_pend_q <= rd_pend_d;
      seen_q    <= seen_d;
      cnt_q     <= cnt_d;
      wr_h_q    <= wr_h_d;
      wr_l_q    <= wr_l_d;
      ack_q     <= ack_d;
      rd_q      <= rd_d;
    end
  end

  assign spi.spi_start_o = state_q inside {WR, RD, USR};
  assign spi.spi_wr_h_o  = wr_h_q;
  assign spi.spi_wr_l_o  = wr_l_q;

  assign init_busy_o = busy_q;
  assign init_done_o = done_q;
  assign init_err_o  = err_q;
  assign err_idx_o   = eidx_q;
  assign usr_ack_o   = ack_q;
  assign usr_rd_o    = rd_q;

endmodule

// File: tb/tb_adc_spi_sequencer.sv
// tb_adc_spi_sequencer: scoreboard bench
// spi_master model with echo register file
module tb_adc_spi_sequencer;
  import adc_spi_pkg::*;

  function automatic table_t mk_tbl();
    table_t t;
    t = '0;
    t[0] = {1'b0, 16'h0014, 16'h0005};
    t[1] = {1'b1, 16'h0016, 16'h00A5};
    return t;
  endfunction

  localparam table_t TB_TABLE = mk_tbl();

  logic        clk;
  logic        rst;
  logic        init_start;
  logic        init_busy_o;
  logic        init_done_o;
  logic        init_err_o;
  logic [4:0]  err_idx_o;
  logic        usr_req;
  logic [15:0] usr_h;
  logic [15:0] usr_l;
  logic        usr_ack_o;
  logic [15:0] usr_rd_o;

  logic        force_a4;
  logic        no_busy;
  logic [15:0] mem [256];
  int          bcnt;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int n_start = 0;
  int n_ack  = 0;
  int start_cyc = 0;
  int ack_cyc   = 0;

  logic [31:0] exp_q [$];
  logic [15:0] ack_q [$];

  adc_spi_sequencer_if spi();

  adc_spi_sequencer #(
    .N_CMD (2),
    .RETRY (3),
    .TMO   (16'd64),
    .TABLE (TB_TABLE)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .init_start_i (init_start),
    .init_busy_o  (init_busy_o),
    .init_done_o  (init_done_o),
    .init_err_o   (init_err_o),
    .err_idx_o    (err_idx_o),
    .usr_req_i    (usr_req),
    .usr_wr_h_i   (usr_h),
    .usr_wr_l_i   (usr_l),
    .usr_ack_o    (usr_ack_o),
    .usr_rd_o     (usr_rd_o),
    .spi          (spi.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
  end

  // spi_master model: 40 busy cycles, echo register file
  always @(posedge clk) begin
    if (rst) begin
      spi.spi_busy_i <= 1'b0;
      spi.spi_rd_l_i <= '0;
      bcnt           <= 0;
    end else if (spi.spi_start_o) begin
      if (!spi.spi_wr_h_o[15]) begin
        mem[spi.spi_wr_h_o[7:0]] <= spi.spi_wr_l_o;
      end else if (force_a4 && spi.spi_wr_h_o[7:0] == 8'h16) begin
        spi.spi_rd_l_i <= 16'h00A4;
      end else begin
        spi.spi_rd_l_i <= mem[spi.spi_wr_h_o[7:0]];
      end
      if (!no_busy) begin
        spi.spi_busy_i <= 1'b1;
        bcnt           <= 40;
      end
    end else if (spi.spi_busy_i) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) spi.spi_busy_i <= 1'b0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
  endtask

  // scoreboard: pop on every start pulse and every ack
  always @(negedge clk) begin
    logic [31:0] e;
    logic [15:0] a;
    if (!rst && spi.spi_start_o) begin
      n_start++;
      start_cyc = cyc;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      chk("spi_start", {spi.spi_wr_h_o, spi.spi_wr_l_o}, e);
    end
    if (!rst && usr_ack_o) begin
      n_ack++;
      ack_cyc = cyc;
      a = (ack_q.size() != 0) ? ack_q.pop_front() : 'x;
      chk("usr_rd", {16'h0, usr_rd_o}, {16'h0, a});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [15:0] h,
                      input logic [15:0] l);
    exp_q.push_back({h, l});
  endtask

  task automatic pulse_init();
    init_start = 1'b1;
    tick(1);
    init_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (init_busy_o && n < 3000) begin
      tick(1);
      n++;
    end
    chk({tag, "_idle_wait"}, 32'(n < 3000), 1);
    tick(5);
  endtask

  task automatic wait_start(input int tgt,
                            input string tag);
    int n = 0;
    while (n_start < tgt && n < 2000) begin
      tick(1);
      n++;
    end
    chk({tag, "_start_wait"}, 32'(n < 2000), 1);
  endtask

  task automatic wait_ack(input string tag);
    int n = 0;
    while (!usr_ack_o && n < 2000) begin
      tick(1);
      n++;
    end
    usr_req = 1'b0;
    chk({tag, "_ack_wait"}, 32'(n < 2000), 1);
    tick(2);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(init_busy_o), 0);
    chk({tag, "_done"}, 32'(init_done_o), 0);
    chk({tag, "_err"}, 32'(init_err_o), 0);
    chk({tag, "_eidx"}, 32'(err_idx_o), 0);
    chk({tag, "_ack"}, 32'(usr_ack_o), 0);
    chk({tag, "_rd"}, 32'(usr_rd_o), 0);
    chk({tag, "_start"}, 32'(spi.spi_start_o), 0);
    chk({tag, "_wr_h"}, 32'(spi.spi_wr_h_o), 0);
    chk({tag, "_wr_l"}, 32'(spi.spi_wr_l_o), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int a;
    int req_cyc;
    rst        = 1'b1;
    init_start = 1'b0;
    usr_req    = 1'b0;
    usr_h      = '0;
    usr_l      = '0;
    force_a4   = 1'b0;
    no_busy    = 1'b0;
    tick(3);
    chk_zero("rst");
    rst = 1'b0;
    tick(10);
    chk("no_spurious_start", 32'(n_start), 0);

    // plain init: WR, WR, RD readback
    b = n_start;
    push(16'h0014, 16'h0005);
    push(16'h0016, 16'h00A5);
    push(16'h8016, 16'h0000);
    pulse_init();
    wait_idle("t1");
    chk("t1_done", 32'(init_done_o), 1);
    chk("t1_err", 32'(init_err_o), 0);
    chk("t1_nstart", 32'(n_start - b), 3);

    // readback mismatch: 4 WR/RD pairs then error
    force_a4 = 1'b1;
    b = n_start;
    push(16'h0014, 16'h0005);
    for (int i = 0; i < 4; i++) begin
      push(16'h0016, 16'h00A5);
      push(16'h8016, 16'h0000);
    end
    pulse_init();
    wait_idle("t2");
    force_a4 = 1'b0;
    chk("t2_err", 32'(init_err_o), 1);
    chk("t2_eidx", 32'(err_idx_o), 1);
    chk("t2_done", 32'(init_done_o), 0);
    chk("t2_nstart", 32'(n_start - b), 9);

    // user read interleaved between entries
    b = n_start;
    a = n_ack;
    push(16'h0014, 16'h0005);
    push(16'h8016, 16'h0000);
    push(16'h0016, 16'h00A5);
    push(16'h8016, 16'h0000);
    ack_q.push_back(16'h00A5);
    pulse_init();
    wait_start(b + 1, "t3");
    usr_h   = 16'h8016;
    usr_l   = 16'h0000;
    usr_req = 1'b1;
    wait_ack("t3");
    wait_idle("t3");
    chk("t3_done", 32'(init_done_o), 1);
    chk("t3_err", 32'(init_err_o), 0);
    chk("t3_nack", 32'(n_ack - a), 1);
    chk("t3_nstart", 32'(n_start - b), 4);

    // silent spi_master: timeout read value
    no_busy = 1'b1;
    push(16'h8016, 16'h0000);
    ack_q.push_back(16'hDEAD);
    usr_h   = 16'h8016;
    usr_l   = 16'h0000;
    usr_req = 1'b1;
    req_cyc = cyc;
    wait_ack("t4");
    no_busy = 1'b0;
    chk("t4_req2start", 32'(start_cyc - req_cyc), 2);
    chk("t4_tmo_lat", 32'(ack_cyc - start_cyc), 64);
    tick(5);

    // reset mid WR_WAIT of entry 1, then restart
    b = n_start;
    push(16'h0014, 16'h0005);
    push(16'h0016, 16'h00A5);
    pulse_init();
    wait_start(b + 2, "t5");
    tick(5);
    rst = 1'b1;
    tick(1);
    chk_zero("t5_rst");
    rst = 1'b0;
    tick(2);
    chk("t5_q", 32'(exp_q.size()), 0);
    b = n_start;
    push(16'h0014, 16'h0005);
    push(16'h0016, 16'h00A5);
    push(16'h8016, 16'h0000);
    pulse_init();
    wait_idle("t5b");
    chk("t5_done", 32'(init_done_o), 1);
    chk("t5_nstart", 32'(n_start - b), 3);

    // init start during user transfer, second start ignored
    b = n_start;
    a = n_ack;
    push(16'h8016, 16'h0000);
    ack_q.push_back(16'h00A5);
    usr_h   = 16'h8016;
    usr_l   = 16'h0000;
    usr_req = 1'b1;
    wait_start(b + 1, "t6");
    tick(3);
    push(16'h0014, 16'h0005);
    push(16'h0016, 16'h00A5);
    push(16'h8016, 16'h0000);
    pulse_init();
    wait_ack("t6");
    wait_start(b + 2, "t6e0");
    tick(1);
    chk("t6_order", 32'(start_cyc > ack_cyc), 1);
    wait_start(b + 3, "t6e1");
    tick(3);
    pulse_init();
    wait_idle("t6");
    chk("t6_done", 32'(init_done_o), 1);
    chk("t6_err", 32'(init_err_o), 0);
    chk("t6_nstart", 32'(n_start - b), 4);
    chk("t6_nack", 32'(n_ack - a), 1);

    chk("spi_q_left", 32'(exp_q.size()), 0);
    chk("ack_q_left", 32'(ack_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
